// File: rtl/riscv_mem_arbiter_if.sv
// Memory-port bundle shared by the two requesters and the downstream memory.
// master drives the request fields; slave returns read data and the completion pulse.
interface riscv_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Two-port arbiter (p0 = fetch, p1 = LSU) onto one memory port, one transaction in flight.
// Optional watchdog completion with bus error enabled by macro ARB_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | no transaction; mem_* low; pick a winner if any port requests
// S_BUSY | granted port's request driven to memory until mem.ready (or watchdog)
module riscv_mem_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    riscv_mem_arbiter_if.slave  p0,
    riscv_mem_arbiter_if.slave  p1,
    riscv_mem_arbiter_if.master mem
`ifdef ARB_TIMEOUT_EN
    ,
    output logic bus_err_o
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q;
    logic        busy;
    logic        timeout;
    logic        done;
    logic [31:0] rd_sel;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("riscv_mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    assign busy = (state_q == S_BUSY);
    assign done = busy && (mem.ready || timeout);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (done) begin
                last_grant_q <= grant_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (p0.req || p1.req) begin
                    state_d = S_BUSY;
                    if (p0.req && p1.req) begin
                        grant_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
                    end else begin
                        grant_d = p1.req;
                    end
                end
            end
            S_BUSY: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Requesters hold their fields stable while busy, so the mux can stay combinational.
    assign mem.req  = busy;
    assign mem.we   = busy & (grant_q ? p1.we : p0.we);
    assign mem.be   = busy ? (grant_q ? p1.be : p0.be) : 4'h0;
    assign mem.addr = busy ? (grant_q ? p1.addr : p0.addr) : 32'h0;
    assign mem.wd   = busy ? (grant_q ? p1.wd : p0.wd) : 32'h0;

    // A watchdog completion only reaches here when mem.ready is low.
    assign rd_sel   = mem.ready ? mem.rd : 32'hDEAD_BEEF;

    assign p0.ready = done & ~grant_q;
    assign p1.ready = done & grant_q;
    assign p0.rd    = p0.ready ? rd_sel : 32'h0;
    assign p1.rd    = p1.ready ? rd_sel : 32'h0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_LOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_LOG < 8) ? 8 : ((CNT_LOG > 16) ? 16 : CNT_LOG);

    logic [CNT_W-1:0] wait_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q <= '0;
        end else if (state_q == S_IDLE) begin
            wait_q <= '0;
        end else if (!mem.ready) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign timeout   = busy && (wait_q == CNT_W'(TIMEOUT_CYCLES));
    assign bus_err_o = timeout && !mem.ready;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_riscv_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    riscv_mem_arbiter_if rr_p0 ();
    riscv_mem_arbiter_if rr_p1 ();
    riscv_mem_arbiter_if rr_mem ();
    riscv_mem_arbiter_if fp_p0 ();
    riscv_mem_arbiter_if fp_p1 ();
    riscv_mem_arbiter_if fp_mem ();

`ifdef ARB_TIMEOUT_EN
    logic rr_err, fp_err;
`endif

    riscv_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk_i(clk_i), .rst_ni(rst_ni), .p0(rr_p0), .p1(rr_p1), .mem(rr_mem)
`ifdef ARB_TIMEOUT_EN
        , .bus_err_o(rr_err)
`endif
    );

    riscv_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(4)) dut_fp (
        .clk_i(clk_i), .rst_ni(rst_ni), .p0(fp_p0), .p1(fp_p1), .mem(fp_mem)
`ifdef ARB_TIMEOUT_EN
        , .bus_err_o(fp_err)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        rr_p0.req = 0; rr_p0.we = 0; rr_p0.be = 0; rr_p0.addr = 0; rr_p0.wd = 0;
        rr_p1.req = 0; rr_p1.we = 0; rr_p1.be = 0; rr_p1.addr = 0; rr_p1.wd = 0;
        fp_p0.req = 0; fp_p0.we = 0; fp_p0.be = 0; fp_p0.addr = 0; fp_p0.wd = 0;
        fp_p1.req = 0; fp_p1.we = 0; fp_p1.be = 0; fp_p1.addr = 0; fp_p1.wd = 0;
        rr_mem.ready = 0; rr_mem.rd = 0; fp_mem.ready = 0; fp_mem.rd = 0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        tick(); tick();
        #1;
        checks++;
        if ({rr_mem.req, rr_mem.we, rr_mem.be, rr_mem.addr, rr_mem.wd, rr_p0.ready, rr_p1.ready,
             rr_p0.rd, rr_p1.rd, fp_mem.req, fp_p0.ready, fp_p1.ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got mem_req=%b p0_ready=%b p1_ready=%b addr=%h, expected all zero",
                     rr_mem.req, rr_p0.ready, rr_p1.ready, rr_mem.addr);
        end
        tick();
        rst_ni = 1'b1;
        rr_p1.req = 1; rr_p1.we = 1; rr_p1.be = 4'hF; rr_p1.addr = 32'h100; rr_p1.wd = 32'h1;
        tick();
        #1;
        checks++;
        if (rr_mem.req !== 1'b1 || rr_mem.addr !== 32'h100) begin
            errors++;
            $display("FAIL reset_pre_busy: got req=%b addr=%h, expected req=1 addr=00000100", rr_mem.req, rr_mem.addr);
        end
        rr_mem.ready = 1; rr_mem.rd = 32'h5555_AAAA;
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({rr_mem.req, rr_mem.we, rr_mem.be, rr_mem.addr, rr_mem.wd, rr_p0.ready, rr_p1.ready, rr_p1.rd} !== '0) begin
            errors++;
            $display("FAIL reset_async: got req=%b p1_ready=%b addr=%h, expected all zero",
                     rr_mem.req, rr_p1.ready, rr_mem.addr);
        end
        tick();
        rst_ni = 1'b1;
        rr_mem.ready = 0;
        rr_p1.req = 0; rr_p1.we = 0;
        rr_p0.req = 1; rr_p0.we = 0; rr_p0.be = 4'hF; rr_p0.addr = 32'h200;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_after: got mem_req=%b, expected 0", rr_mem.req);
        end
        tick();
        rr_mem.ready = 1; rr_mem.rd = 32'h0BAD_F00D;
        #1;
        checks++;
        if (rr_mem.req !== 1'b1 || rr_mem.addr !== 32'h200 || rr_p0.ready !== 1'b1 || rr_p1.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_grant: got req=%b addr=%h p0_ready=%b p1_ready=%b, expected 1 00000200 1 0",
                     rr_mem.req, rr_mem.addr, rr_p0.ready, rr_p1.ready);
        end
        tick();
        rr_p0.req = 0; rr_mem.ready = 0;
    endtask

    task automatic test_single_read();
        tick();
        rr_p0.req = 1; rr_p0.we = 0; rr_p0.be = 4'hF; rr_p0.addr = 32'h0000_0010; rr_p0.wd = 0;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got mem_req=%b, expected 0", rr_mem.req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            rr_mem.ready = (i == 2);
            rr_mem.rd    = (i == 2) ? 32'h1234_5678 : $urandom;
            #1;
            checks++;
            if (rr_mem.req !== 1'b1 || rr_mem.addr !== 32'h10 || rr_mem.we !== 1'b0 ||
                rr_p0.ready !== (i == 2) || rr_p0.rd !== ((i == 2) ? 32'h1234_5678 : 32'h0) ||
                rr_p1.ready !== 1'b0) begin
                errors++;
                $display("FAIL read_busy[%0d]: got req=%b addr=%h p0_ready=%b p0_rd=%h p1_ready=%b", i,
                         rr_mem.req, rr_mem.addr, rr_p0.ready, rr_p0.rd, rr_p1.ready);
            end
        end
        tick();
        rr_p0.req = 0; rr_mem.ready = 0;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0 || rr_p0.ready !== 1'b0 || rr_p0.rd !== 32'h0) begin
            errors++;
            $display("FAIL read_after: got req=%b p0_ready=%b p0_rd=%h, expected 0 0 0", rr_mem.req, rr_p0.ready, rr_p0.rd);
        end
    endtask

    task automatic test_write_p1();
        tick();
        rr_p1.req = 1; rr_p1.we = 1; rr_p1.be = 4'b0011; rr_p1.addr = 32'h40; rr_p1.wd = 32'hAABB_CCDD;
        tick();
        rr_mem.ready = 1; rr_mem.rd = 32'h55;
        #1;
        checks++;
        if (rr_mem.req !== 1'b1 || rr_mem.we !== 1'b1 || rr_mem.be !== 4'b0011 || rr_mem.wd !== 32'hAABB_CCDD ||
            rr_p1.ready !== 1'b1 || rr_p1.rd !== 32'h55 || rr_p0.ready !== 1'b0 || rr_p0.rd !== 32'h0) begin
            errors++;
            $display("FAIL write_p1: got we=%b be=%b wd=%h p1_ready=%b p1_rd=%h p0_ready=%b",
                     rr_mem.we, rr_mem.be, rr_mem.wd, rr_p1.ready, rr_p1.rd, rr_p0.ready);
        end
        tick();
        rr_p1.req = 0; rr_p1.we = 0; rr_mem.ready = 0;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0 || rr_mem.we !== 1'b0 || rr_p1.ready !== 1'b0) begin
            errors++;
            $display("FAIL write_after: got req=%b we=%b p1_ready=%b, expected 0 0 0", rr_mem.req, rr_mem.we, rr_p1.ready);
        end
    endtask

    // Last completion was p1, so continuous contention must alternate starting with p0.
    task automatic test_round_robin();
        int exp_port;
        tick();
        rr_p0.req = 1; rr_p0.addr = 32'h1000; rr_p0.be = 4'hF;
        rr_p1.req = 1; rr_p1.addr = 32'h2000; rr_p1.be = 4'hF;
        for (int t = 0; t < 4; t++) begin
            #1;
            checks++;
            if (rr_mem.req !== 1'b0) begin
                errors++;
                $display("FAIL rr_bubble[%0d]: got mem_req=%b, expected 0", t, rr_mem.req);
            end
            tick();
            rr_mem.ready = 1; rr_mem.rd = 32'hC0DE_0000 + t;
            exp_port = t % 2;
            #1;
            checks++;
            if (rr_mem.addr !== (exp_port ? 32'h2000 : 32'h1000) || rr_p0.ready !== (exp_port == 0) ||
                rr_p1.ready !== (exp_port == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got addr=%h p0_ready=%b p1_ready=%b, expected port %0d", t,
                         rr_mem.addr, rr_p0.ready, rr_p1.ready, exp_port);
            end
            tick();
            rr_mem.ready = 0;
        end
        rr_p0.req = 0; rr_p1.req = 0;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0) begin
            errors++;
            $display("FAIL rr_end: got mem_req=%b, expected 0", rr_mem.req);
        end
    endtask

    task automatic test_fixed_prio();
        int exp_port;
        tick();
        fp_p0.req = 1; fp_p0.addr = 32'h3000; fp_p0.be = 4'hF;
        fp_p1.req = 1; fp_p1.addr = 32'h4000; fp_p1.be = 4'hF;
        for (int t = 0; t < 4; t++) begin
            tick();
            fp_mem.ready = 1; fp_mem.rd = 32'hF00D_0000 + t;
            exp_port = (t < 3) ? 1 : 0;
            #1;
            checks++;
            if (fp_mem.addr !== (exp_port ? 32'h4000 : 32'h3000) || fp_p0.ready !== (exp_port == 0) ||
                fp_p1.ready !== (exp_port == 1)) begin
                errors++;
                $display("FAIL fp_grant[%0d]: got addr=%h p0_ready=%b p1_ready=%b, expected port %0d", t,
                         fp_mem.addr, fp_p0.ready, fp_p1.ready, exp_port);
            end
            tick();
            fp_mem.ready = 0;
            if (t == 2) fp_p1.req = 0;
        end
        fp_p0.req = 0; fp_p1.req = 0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        tick();
        rr_p0.req = 1; rr_p0.we = 0; rr_p0.addr = 32'h300; rr_p0.be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            rr_mem.ready = 0;
            #1;
            checks++;
            if (rr_mem.req !== 1'b1 || rr_p0.ready !== (i == 4) || rr_err !== (i == 4) ||
                rr_p0.rd !== ((i == 4) ? 32'hDEAD_BEEF : 32'h0)) begin
                errors++;
                $display("FAIL timeout[%0d]: got req=%b p0_ready=%b err=%b rd=%h", i, rr_mem.req, rr_p0.ready, rr_err, rr_p0.rd);
            end
        end
        tick();
        rr_p0.req = 0;
        #1;
        checks++;
        if (rr_mem.req !== 1'b0 || rr_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: got req=%b err=%b, expected 0 0", rr_mem.req, rr_err);
        end
        rr_p1.req = 1; rr_p1.we = 0; rr_p1.addr = 32'h304; rr_p1.be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            rr_mem.ready = (i == 4); rr_mem.rd = 32'h77;
            #1;
            checks++;
            if (rr_p1.ready !== (i == 4) || rr_err !== 1'b0 || rr_p1.rd !== ((i == 4) ? 32'h77 : 32'h0)) begin
                errors++;
                $display("FAIL timeout_tie[%0d]: got p1_ready=%b err=%b rd=%h", i, rr_p1.ready, rr_err, rr_p1.rd);
            end
        end
        tick();
        rr_p1.req = 0; rr_mem.ready = 0;
    endtask
`endif

    // Transaction-level model: pending request per port, one job in service, alternate on contention.
    bit          pv [2];
    logic        pwe[2];
    logic [3:0]  pbe[2];
    logic [31:0] pad[2];
    logic [31:0] pwd[2];
    bit          m_busy;
    int          m_port, m_left, m_last;
    int          served[2];

    task automatic test_random();
        logic [31:0] data;
        logic [1:0]  rdy;
        logic [31:0] rdv[2];
        bit          fin;
        m_busy = 0; m_last = 1; served[0] = 0; served[1] = 0;
        pv[0] = 0; pv[1] = 0;
        fin = 0;
        for (int cyc = 0; cyc < 800 && !fin; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && cyc < 600 && $urandom_range(0, 1) == 1) begin
                    pv[p] = 1; pwe[p] = 1'($urandom); pbe[p] = 4'($urandom);
                    pad[p] = $urandom; pwd[p] = $urandom;
                end
            end
            rr_p0.req = pv[0]; rr_p0.we = pwe[0]; rr_p0.be = pbe[0]; rr_p0.addr = pad[0]; rr_p0.wd = pwd[0];
            rr_p1.req = pv[1]; rr_p1.we = pwe[1]; rr_p1.be = pbe[1]; rr_p1.addr = pad[1]; rr_p1.wd = pwd[1];
            data = $urandom;
            rr_mem.rd    = data;
            rr_mem.ready = m_busy ? (m_left == 1) : ($urandom_range(0, 3) == 0);
            #1;
            rdy = {rr_p1.ready, rr_p0.ready};
            rdv[0] = rr_p0.rd; rdv[1] = rr_p1.rd;
            checks++;
            if (!m_busy) begin
                if (rr_mem.req !== 1'b0 || rdy !== 2'b00 || rdv[0] !== 32'h0 || rdv[1] !== 32'h0) begin
                    errors++;
                    $display("FAIL rnd_idle cyc %0d: got req=%b ready=%b, expected idle", cyc, rr_mem.req, rdy);
                end
            end else begin
                if (rr_mem.req !== 1'b1 || rr_mem.addr !== pad[m_port] || rr_mem.we !== pwe[m_port] ||
                    rr_mem.be !== pbe[m_port] || rr_mem.wd !== pwd[m_port] ||
                    rdy[m_port] !== (m_left == 1) || rdy[1-m_port] !== 1'b0 ||
                    rdv[m_port] !== ((m_left == 1) ? data : 32'h0) || rdv[1-m_port] !== 32'h0) begin
                    errors++;
                    $display("FAIL rnd_busy cyc %0d: got addr=%h ready=%b, expected port %0d addr=%h done=%0d",
                             cyc, rr_mem.addr, rdy, m_port, pad[m_port], (m_left == 1));
                end
            end
            if (m_busy) begin
                if (m_left == 1) begin
                    pv[m_port] = 0; m_last = m_port; m_busy = 0; served[m_port]++;
                end else begin
                    m_left--;
                end
            end else if (pv[0] || pv[1]) begin
                m_port = (pv[0] && pv[1]) ? 1 - m_last : (pv[1] ? 1 : 0);
                m_busy = 1;
                m_left = $urandom_range(1, 3);
            end
            if (cyc >= 600 && !m_busy && !pv[0] && !pv[1]) fin = 1;
        end
        tick();
        rr_p0.req = 0; rr_p1.req = 0; rr_mem.ready = 0;
        checks++;
        if (!fin || served[0] < 10 || served[1] < 10) begin
            errors++;
            $display("FAIL rnd_progress: got drained=%0d served p0=%0d p1=%0d, expected drained with >=10 each",
                     fin, served[0], served[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_p1();
        test_round_robin();
        test_fixed_prio();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Two-requester arbiter sharing one data-memory port between instruction fetch (port 0) and the load/store unit (port 1).
- Each side uses the same req/we/be/addr/wd/rd/ready protocol as the memory-side interface of the core's LSU; multi-cycle memory completion is tracked via mem_ready_i.
- Sits between core/LSU and the memory or peripheral interconnect.
- Round-robin or fixed priority selectable by parameter; at most one outstanding memory transaction.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 1 (LSU) always wins ties.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  asynchronous active-low reset
- p0_req_i  input  1  port 0 request, held until p0_ready_o
- p0_we_i  input  1  port 0 write enable
- p0_be_i  input  4  port 0 byte enables
- p0_addr_i  input  32  port 0 address
- p0_wd_i  input  32  port 0 write data
- p0_rd_o  output  32  port 0 read data, valid while p0_ready_o=1
- p0_ready_o  output  1  port 0 completion pulse
- p1_req_i, p1_we_i, p1_be_i, p1_addr_i, p1_wd_i, p1_rd_o, p1_ready_o  same as port 0, for port 1
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_be_o  output  4  memory byte enables
- mem_addr_o  output  32  memory address
- mem_wd_o  output  32  memory write data
- mem_rd_i  input  32  memory read data
- mem_ready_i  input  1  memory completion, one cycle

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE, grant=0, last_grant=1; all outputs 0. Reset mid-transaction abandons it; no ready pulse is issued.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - All mem_* outputs 0.
  - If any req_i=1, select a winner, register it in grant, go to BUSY.
  - Single requester: that requester wins.
  - Both requesting, FIXED_PRIO=1: port 1 wins.
  - Both requesting, FIXED_PRIO=0: the port not equal to last_grant wins.
- BUSY:
  - mem_req_o=1; mem_we/be/addr/wd are driven combinationally from the granted port's inputs (requester holds them stable).
  - On mem_ready_i=1: granted pX_ready_o=1 for that cycle, pX_rd_o=mem_rd_i, last_grant<=grant, next state IDLE.
  - Otherwise remain in BUSY.
- Latency: request sampled in IDLE at cycle N; mem_req_o=1 from N+1; ready in the same cycle as mem_ready_i. Minimum 2 cycles per transaction; one IDLE bubble between back-to-back transactions.
- Non-granted port: ready_o=0, rd_o=32'h0, always. rd_o of the granted port is 32'h0 outside its ready cycle.
- mem_ready_i in IDLE is ignored.
- Requester drops req_i while BUSY: protocol violation, behaviour unspecified; the bench must not do this.
- Requester keeps req_i=1 after ready: treated as a new request at the next IDLE.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Adds output bus_err_o (1 bit, reset 0) and an 8..16-bit wait counter sized to hold TIMEOUT_CYCLES.
  - Counter clears on entry to BUSY and increments each BUSY cycle without mem_ready_i.
  - When it reaches TIMEOUT_CYCLES: granted pX_ready_o=1, pX_rd_o=32'hDEAD_BEEF, bus_err_o=1 for that cycle, mem_req_o=0 next cycle, go to IDLE, last_grant updated.
  - If mem_ready_i coincides with the timeout cycle, the normal completion wins and bus_err_o stays 0.
- Undefined: no counter and no bus_err_o port; the arbiter waits indefinitely.

Test Plan:
- Reset: assert rst_ni=0 mid-BUSY with p1 granted -> all outputs 0 immediately; after release, p0-only request granted first.
- Single port 0 read: addr 0x0000_0010, memory ready after 3 cycles with 0x1234_5678 -> mem_req_o high 3 cycles, p0_ready_o one pulse, p0_rd_o=0x1234_5678, p1_ready_o=0.
- Port 1 write: be=4'b0011, wd=0xAABB_CCDD -> mem_we_o=1, mem_be_o=0011, mem_wd_o=0xAABB_CCDD; p1_ready_o pulses with mem_ready_i.
- FIXED_PRIO=0, both ports requesting continuously with 1-cycle memory -> grant sequence p0,p1,p0,p1; one IDLE cycle between each.
- FIXED_PRIO=1, both requesting -> port 1 served every transaction; port 0 served only after p1_req_i drops.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never ready -> after 4 BUSY cycles: p0_ready_o=1, p0_rd_o=0xDEADBEEF, bus_err_o=1; return to IDLE.
